// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the rhythm-game blocks.
//   chart_entry_t : one chart ROM word {delta, octave, note, length}
//   seq_state_t   : goal_sequencer state encoding
//   P/S/A/B/C     : hit-window edges in game ticks (C is the miss horizon)
//   DIFF_STEP     : ticks removed from the miss horizon per difficulty step
package game_pkg;

  typedef struct packed {
    logic [15:0] delta;   // ticks from previous goal
    logic [2:0]  octave;
    logic [2:0]  note;
    logic [3:0]  length;  // 0 marks end of chart
  } chart_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    ARMED,
    DONE
  } seq_state_t;

  localparam int unsigned P = 16;
  localparam int unsigned S = 64;
  localparam int unsigned A = 97;
  localparam int unsigned B = 127;
  localparam int unsigned C = 188;

  localparam int unsigned DIFF_STEP = 3;

endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: game tick prescaler.
//   clk, rst_n : clock, async active-low reset
//   enable     : count clk cycles while high (holds count while low)
//   clear      : synchronous restart of the prescaler
//   tick       : 1-cycle pulse every TICK_DIV enabled cycles
module game_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clear)       cnt <= '0;
    else if (enable) begin
      if (cnt == LAST)    cnt <= '0;
      else                cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/goal_sequencer.sv
// goal_sequencer: walks a chart ROM, arms one goal at a time against the
// running game clock, and retires it on a hit or on window expiry.
//   clk, rst_n     : clock, async active-low reset
//   start          : pulse, restart chart from address 0
//   pause          : level, freezes tick counting and miss detection
//   difficulty     : shrinks the miss horizon by difficulty*DIFF_STEP ticks
//   hit            : pulse, player input (only honoured while ARMED)
//   rom_addr/data  : chart ROM port, data valid one cycle after address
//   game_clock     : elapsed game ticks
//   goal_*         : current goal (absolute tick, octave, note, length, armed)
//   miss           : 1-cycle pulse when a goal expires unhit
//   now_cnt        : goals retired, saturating
//   done           : chart finished
// Optional build macro AUTOPLAY_EN adds input autoplay and output auto_hit:
// the block hits each goal itself exactly on its tick.
module goal_sequencer
  import game_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [3:0]        difficulty,
  input  logic              hit,
`ifdef AUTOPLAY_EN
  input  logic              autoplay,
  output logic              auto_hit,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [25:0]       rom_data,
  output logic [31:0]       game_clock,
  output logic [31:0]       goal_clock,
  output logic [2:0]        goal_octave,
  output logic [2:0]        goal_note,
  output logic [3:0]        goal_length,
  output logic              goal_valid,
  output logic              miss,
  output logic [20:0]       now_cnt,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  seq_state_t   state, state_d;
  chart_entry_t entry;
  logic         tick, tick_en;
  logic         hit_int, expire, retire;
  logic         addr_end;   // armed goal came from the last ROM word
  logic [31:0]  deadline;

  assign entry   = chart_entry_t'(rom_data);
  assign tick_en = (state != IDLE) && (state != DONE) && !pause;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tick_en),
    .clear  (start),
    .tick   (tick)
  );

`ifdef AUTOPLAY_EN
  logic auto_fire;
  assign auto_fire = autoplay && (state == ARMED) && (game_clock == goal_clock);
  assign hit_int   = hit || auto_fire;
`else
  assign hit_int   = hit;
`endif

  // Miss horizon; unsigned 32-bit arithmetic, wrap is accepted.
  assign deadline = goal_clock + 32'(C) - 32'(difficulty) * 32'(DIFF_STEP);
  assign expire   = (state == ARMED) && !pause && (game_clock >= deadline);
  // A hit outranks a same-cycle expiry.
  assign retire   = (state == ARMED) && (hit_int || expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = IDLE;
      FETCH:    state_d = WAIT_ROM;
      WAIT_ROM: state_d = (entry.length == 4'd0) ? DONE : ARMED;
      ARMED:    if (retire) state_d = addr_end ? DONE : FETCH;
      DONE:     state_d = DONE;
      default:  state_d = IDLE;
    endcase
    if (start) state_d = FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr    <= '0;
      game_clock  <= '0;
      goal_clock  <= '0;
      goal_octave <= '0;
      goal_note   <= '0;
      goal_length <= '0;
      goal_valid  <= 1'b0;
      miss        <= 1'b0;
      now_cnt     <= '0;
      done        <= 1'b0;
      addr_end    <= 1'b0;
`ifdef AUTOPLAY_EN
      auto_hit    <= 1'b0;
`endif
    end else begin
      miss <= 1'b0;
`ifdef AUTOPLAY_EN
      auto_hit <= 1'b0;
`endif
      if (tick) game_clock <= game_clock + 32'd1;

      if (start) begin
        rom_addr   <= '0;
        game_clock <= '0;
        goal_clock <= '0;
        goal_valid <= 1'b0;
        now_cnt    <= '0;
        done       <= 1'b0;
        addr_end   <= 1'b0;
      end else begin
        case (state)
          WAIT_ROM: begin
            if (entry.length == 4'd0) begin
              done       <= 1'b1;
              goal_valid <= 1'b0;
            end else begin
              goal_clock  <= goal_clock + 32'(entry.delta);
              goal_octave <= entry.octave;
              goal_note   <= entry.note;
              goal_length <= entry.length;
              goal_valid  <= 1'b1;
              // No wrap: the last word is still played, then the chart ends.
              if (rom_addr == ADDR_MAX) addr_end <= 1'b1;
              else                      rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
          ARMED: begin
            if (retire) begin
              goal_valid <= 1'b0;
              miss       <= !hit_int;
              if (now_cnt != '1) now_cnt <= now_cnt + 21'd1;
              if (addr_end) done <= 1'b1;
`ifdef AUTOPLAY_EN
              auto_hit   <= auto_fire;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goal_sequencer.sv
// Directed bench for goal_sequencer with a scoreboard: expected goal ticks,
// miss ticks (and auto_hit ticks with AUTOPLAY_EN) are queued when a chart
// is started and checked by a monitor as the DUT produces them.
module tb_goal_sequencer;

  localparam int ADDR_W   = 10;
  localparam int TICK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [3:0]        difficulty = 4'd0;
  logic              hit = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [25:0]       rom_data = '0;
  logic [31:0]       game_clock, goal_clock;
  logic [2:0]        goal_octave, goal_note;
  logic [3:0]        goal_length;
  logic              goal_valid, miss, done;
  logic [20:0]       now_cnt;
`ifdef AUTOPLAY_EN
  logic              autoplay = 1'b0;
  logic              auto_hit;
`endif

  goal_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .difficulty  (difficulty),
    .hit         (hit),
`ifdef AUTOPLAY_EN
    .autoplay    (autoplay),
    .auto_hit    (auto_hit),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .game_clock  (game_clock),
    .goal_clock  (goal_clock),
    .goal_octave (goal_octave),
    .goal_note   (goal_note),
    .goal_length (goal_length),
    .goal_valid  (goal_valid),
    .miss        (miss),
    .now_cnt     (now_cnt),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Chart ROM, one-cycle read latency; addresses past the table read 0.
  logic [25:0] rom [16];
  always @(posedge clk)
    rom_data <= (rom_addr < 10'd16) ? rom[rom_addr[3:0]] : 26'd0;

  int tests = 0;
  int fails = 0;
  int miss_seen = 0;
  logic [31:0] exp_goal_q[$];
  logic [31:0] exp_miss_q[$];
  logic [31:0] exp_auto_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] ent(input int d, input int o, input int n, input int l);
    return {16'(d), 3'(o), 3'(n), 4'(l)};
  endfunction

  // Scoreboard monitor.
  logic gv_q = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (goal_valid && !gv_q) begin
      e = (exp_goal_q.size() != 0) ? exp_goal_q.pop_front() : 32'hxxxx_xxxx;
      check("goal_clock_on_arm", goal_clock, e);
    end
    if (miss) begin
      miss_seen++;
      e = (exp_miss_q.size() != 0) ? exp_miss_q.pop_front() : 32'hxxxx_xxxx;
      check("miss_at_game_clock", game_clock, e);
    end
`ifdef AUTOPLAY_EN
    if (auto_hit) begin
      e = (exp_auto_q.size() != 0) ? exp_auto_q.pop_front() : 32'hxxxx_xxxx;
      check("auto_hit_at_game_clock", game_clock, e);
    end
`endif
    gv_q = goal_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk); hit = 1'b0;
  endtask

  task automatic wait_gc(input logic [31:0] v, input int bound);
    int k = 0;
    while (game_clock !== v && k < bound) begin @(negedge clk); k++; end
    check("reach_game_clock", game_clock, v);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin @(negedge clk); k++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    int ms;
    for (int i = 0; i < 16; i++) rom[i] = '0;

    // Reset state, and IDLE must not count ticks.
    cycles(2);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_game_clock", game_clock, 32'd0);
    check("rst_goal_valid", 32'(goal_valid), 32'd0);
    check("rst_now_cnt", 32'(now_cnt), 32'd0);
    check("rst_done_miss", {30'd0, done, miss}, 32'd0);
    rst_n = 1'b1;
    cycles(10);
    check("idle_no_tick", game_clock, 32'd0);

    // Two goals, both hit on time.
    rom[0] = ent(10, 2, 3, 1);
    rom[1] = ent(5, 4, 5, 2);
    rom[2] = '0;
    exp_goal_q.push_back(32'd10);
    exp_goal_q.push_back(32'd15);
    do_start();
    wait_gc(32'd10, 200);
    check("goal1_fields", {22'd0, goal_octave, goal_note, goal_length}, {22'd0, 3'd2, 3'd3, 4'd1});
    pulse_hit();
    check("retire_gv_low", 32'(goal_valid), 32'd0);
    cycles(1);
    check("latency_c2_low", 32'(goal_valid), 32'd0);
    cycles(1);
    check("latency_c3_high", 32'(goal_valid), 32'd1);
    check("goal2_fields", {22'd0, goal_octave, goal_note, goal_length}, {22'd0, 3'd4, 3'd5, 4'd2});
    wait_gc(32'd15, 200);
    pulse_hit();
    cycles(3);
    check("s1_done", 32'(done), 32'd1);
    check("s1_now_cnt", 32'(now_cnt), 32'd2);
    check("s1_goal_clock", goal_clock, 32'd15);
    check("s1_goal_valid", 32'(goal_valid), 32'd0);
    check("s1_rom_addr", 32'(rom_addr), 32'd2);
    check("s1_no_miss", 32'(miss_seen), 32'd0);
    g = game_clock;
    pulse_hit();
    cycles(20);
    check("hit_in_done_ignored", 32'(now_cnt), 32'd2);
    check("done_clock_frozen", game_clock, g);

    // Single goal, no hit, difficulty 0: miss at 10+188.
    rom[0] = ent(10, 1, 1, 4);
    rom[1] = '0;
    difficulty = 4'd0;
    exp_goal_q.push_back(32'd10);
    exp_miss_q.push_back(32'd198);
    do_start();
    check("start_clears_now_cnt", 32'(now_cnt), 32'd0);
    check("start_clears_done", 32'(done), 32'd0);
    wait_done(2000);
    check("s2_now_cnt", 32'(now_cnt), 32'd1);
    check("s2_miss_count", 32'(miss_seen), 32'd1);

    // Difficulty 5: miss at 10+188-15.
    difficulty = 4'd5;
    exp_goal_q.push_back(32'd10);
    exp_miss_q.push_back(32'd183);
    do_start();
    wait_done(2000);
    check("s3_now_cnt", 32'(now_cnt), 32'd1);
    check("s3_miss_count", 32'(miss_seen), 32'd2);

    // Hit lands in the same cycle the window expires.
    difficulty = 4'd0;
    exp_goal_q.push_back(32'd10);
    do_start();
    wait_gc(32'd198, 2000);
    pulse_hit();
    wait_done(50);
    check("s4_now_cnt", 32'(now_cnt), 32'd1);
    check("s4_hit_beats_miss", 32'(miss_seen), 32'd2);

    // Pause freezes the clock; then reset mid-chart.
    exp_goal_q.push_back(32'd10);
    do_start();
    wait_gc(32'd5, 200);
    pause = 1'b1;
    cycles(1);
    g = game_clock;
    cycles(100);
    check("pause_clock_frozen", game_clock, g);
    check("pause_goal_armed", 32'(goal_valid), 32'd1);
    pause = 1'b0;
    wait_gc(32'd20, 200);
    ms = miss_seen;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_mid_game_clock", game_clock, 32'd0);
    check("rst_mid_goal_clock", goal_clock, 32'd0);
    check("rst_mid_goal_fields", {22'd0, goal_octave, goal_note, goal_length}, 32'd0);
    check("rst_mid_flags", {28'd0, goal_valid, miss, done, 1'b0}, 32'd0);
    check("rst_mid_now_cnt", 32'(now_cnt), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    check("rst_no_miss", 32'(miss_seen), 32'(ms));
    check("post_rst_idle_clock", game_clock, 32'd0);
    check("post_rst_idle_addr", 32'(rom_addr), 32'd0);

`ifdef AUTOPLAY_EN
    rom[0] = ent(10, 2, 3, 1);
    rom[1] = ent(5, 4, 5, 2);
    rom[2] = '0;
    autoplay = 1'b1;
    exp_goal_q.push_back(32'd10);
    exp_goal_q.push_back(32'd15);
    exp_auto_q.push_back(32'd10);
    exp_auto_q.push_back(32'd15);
    ms = miss_seen;
    do_start();
    wait_done(1000);
    check("auto_now_cnt", 32'(now_cnt), 32'd2);
    check("auto_no_miss", 32'(miss_seen), 32'(ms));
    check("auto_q_drained", 32'(exp_auto_q.size()), 32'd0);
    autoplay = 1'b0;
`endif

    check("goal_q_drained", 32'(exp_goal_q.size()), 32'd0);
    check("miss_q_drained", 32'(exp_miss_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/goal_sequencer.md
GOAL_SEQUENCER -- requirements
Module: goal_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- ADDR_W, 10, chart ROM address width.
- TICK_DIV, 50000, clk cycles per game tick.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse; begins chart from address 0.
- pause, in, 1, level; freezes tick counting and miss detection.
- difficulty, in, 4, shrinks miss window by difficulty*3 ticks.
- hit, in, 1, pulse; player input consumed against the current goal.
- rom_addr, out, ADDR_W, chart ROM address.
- rom_data, in, 26, {delta[25:10], octave[9:7], note[6:4], length[3:0]}; 1-cycle read latency.
- game_clock, out, 32, elapsed game ticks.
- goal_clock, out, 32, absolute tick of the current goal.
- goal_octave, out, 3, current goal octave.
- goal_note, out, 3, current goal note.
- goal_length, out, 4, current goal length.
- goal_valid, out, 1, current goal is armed.
- miss, out, 1, 1-cycle pulse; goal expired unhit.
- now_cnt, out, 21, goals retired (hit or missed).
- done, out, 1, level; chart finished.

Function
REQ-003 States SHALL be IDLE, FETCH, WAIT_ROM, ARMED and DONE.
REQ-004 start in any state SHALL perform all of the following:
- clear game_clock, goal_clock, now_cnt and done;
- set rom_addr to 0;
- enter FETCH.
REQ-005 FETCH SHALL drive rom_addr and go to WAIT_ROM the next cycle.
REQ-006 In WAIT_ROM with rom_data.length==0 (terminator), the block SHALL enter DONE, set done=1 and keep goal_valid=0.
REQ-007 In WAIT_ROM otherwise, the block SHALL:
- set goal_clock = goal_clock + delta (32-bit, zero-extended delta);
- latch octave, note and length;
- set goal_valid=1;
- increment rom_addr;
- enter ARMED.
REQ-008 game_clock SHALL increment by 1 every TICK_DIV clk cycles, only while not IDLE/DONE and pause=0; it SHALL wrap modulo 2^32.
REQ-009 In ARMED, hit=1 SHALL retire the goal: goal_valid=0, now_cnt+1, enter FETCH next cycle. This applies regardless of timing; the downstream scorer grades the hit.
REQ-010 In ARMED with pause=0, the goal SHALL expire when game_clock >= goal_clock + 188 - difficulty*3 (unsigned, computed at 32 bits). On expiry the block SHALL pulse miss for 1 cycle, set goal_valid=0, increment now_cnt and enter FETCH.
REQ-011 If hit and expiry occur in the same cycle, hit SHALL win and miss SHALL stay 0.
REQ-012 hit outside ARMED SHALL be ignored.
REQ-013 now_cnt SHALL saturate at 2^21-1.
REQ-014 rom_addr SHALL NOT wrap; reaching 2^ADDR_W-1 after arming SHALL force DONE on the next retire.
REQ-015 Retire-to-next-goal_valid latency SHALL be 3 cycles (FETCH, WAIT_ROM, ARMED).

Reset
REQ-016 While rst_n=0 the block SHALL immediately hold:
- state=IDLE;
- all outputs 0, including rom_addr, game_clock, goal_*, now_cnt, miss and done;
- the tick prescaler cleared.
REQ-017 Reset asserted mid-chart SHALL abort without emitting a miss pulse.

Configuration
REQ-018 With AUTOPLAY_EN defined, the block SHALL have an extra input autoplay (1 bit). With autoplay=1 in ARMED and game_clock==goal_clock, the block SHALL generate an internal hit and drive output auto_hit (1-cycle pulse) so that the scorer sees a perfect input.
REQ-019 Without AUTOPLAY_EN, the ports autoplay and auto_hit SHALL NOT exist and behaviour SHALL be unchanged.

Structure
REQ-020 Shared package game_pkg SHALL hold:
- the chart entry typedef (delta/octave/note/length fields);
- window constants P=16, S=64, A=97, B=127, C=188;
- DIFF_STEP=3.
REQ-021 The tick prescaler SHALL be a sub-module game_tick_gen (inputs clk, rst_n, enable, clear; output tick pulse).

Verification
REQ-022 Directed scenarios (TICK_DIV=4):
- Chart {delta=10, n1}, {delta=5, n2}, terminator; hit at game_clock=10 and at 15 -> goal_clock 10 then 15, now_cnt=2, done=1, miss never asserted.
- Single goal delta=10, difficulty=0, no hit -> miss pulse exactly when game_clock reaches 198, now_cnt=1.
- Same goal with difficulty=5 -> miss at game_clock 183.
- hit in the same cycle as expiry -> miss=0, now_cnt=1.
- pause held 100 cycles in ARMED -> game_clock frozen, no miss; rst_n pulse mid-chart -> all outputs 0, state IDLE.
- AUTOPLAY_EN with autoplay=1 -> auto_hit at game_clock==goal_clock for every note, zero misses.
